add8_seq: RTL and testbench

Bit-serial ripple adder that computes s = a + b + ci over WIDTH clock cycles, one bit per cycle, LSB first, using a single one-bit full adder. It is the additive counterpart of the parallel 8-bit subtractor in the arithmetic library. It gives the datapath an area-minimal adder with a start/done handshake for slow control paths where a full-width ripple chain is not justified.

---
 rtl/add8_pkg.sv | 13 +
 rtl/add8_seq_if.sv | 32 +++
 rtl/add8_seq_fa1.sv | 15 +
 rtl/add8_seq.sv | 105 ++++++++++
 tb/tb_add8_seq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/add8_pkg.sv
// add8_pkg: shared definitions for the bit-serial adder add8_seq.
//   ADD8_WIDTH   default operand/result width
//   add8_state_e controller state encoding (IDLE=1'b0, RUN=1'b1)
package add8_pkg;

  localparam int ADD8_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } add8_state_e;

endpackage

// File: rtl/add8_seq_if.sv
// add8_seq_if: start/done handshake and operand/result bus of add8_seq.
//   start, a, b, ci   requester -> adder
//   sub               requester -> adder, only when ADD8_SUB_MODE_EN is defined
//   busy, done, s, co adder -> requester
// Modports: master (requester side), slave (adder side).
interface add8_seq_if
  import add8_pkg::*;
#(
  parameter int WIDTH = ADD8_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
`ifdef ADD8_SUB_MODE_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

`ifdef ADD8_SUB_MODE_EN
  modport master (output start, a, b, ci, sub, input busy, done, s, co);
  modport slave  (input start, a, b, ci, sub, output busy, done, s, co);
`else
  modport master (output start, a, b, ci, input busy, done, s, co);
  modport slave  (input start, a, b, ci, output busy, done, s, co);
`endif

endinterface

// File: rtl/add8_seq_fa1.sv
// fa1: combinational one-bit full adder.
//   a, b, ci  input bits
//   s, co     sum and carry-out
module fa1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/add8_seq.sv
// add8_seq: bit-serial adder, {co,s} = a + b + ci over WIDTH cycles, LSB first,
// through a single one-bit full adder.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    add8_seq_if slave: start/a/b/ci(/sub) in, busy/done/s/co out
// Optional feature macro: ADD8_SUB_MODE_EN (adds bus.sub; sub=1 inverts b at capture).
//
// state | meaning
// IDLE  | waiting for start, busy=0
// RUN   | one result bit per edge, busy=1
module add8_seq
  import add8_pkg::*;
#(
  parameter int WIDTH = ADD8_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  add8_seq_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  add8_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] b_cap_d;
  logic             c_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             fa_s;
  logic             fa_co;

  fa1 u_fa1 (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_d = {fa_s, res_q[WIDTH-1:1]};

`ifdef ADD8_SUB_MODE_EN
  assign b_cap_d = bus.sub ? ~bus.b : bus.b;
`else
  assign b_cap_d = bus.b;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= b_cap_d;
            c_q     <= bus.ci;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          c_q    <= fa_co;
          res_q  <= res_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            s_q     <= res_d;
            co_q    <= fa_co;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;

endmodule

// File: tb/tb_add8_seq.sv
module tb_add8_seq;
  import add8_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [W-1:0] prev_s  = '0;
  logic         prev_co = 1'b0;

  add8_seq_if #(.WIDTH(W)) bus ();

  add8_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic on the captured operands.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sub);
    logic [W-1:0] bb;
    bb = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
  endfunction

  // Called at a negedge while the adder is idle; returns at the negedge after E0.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sub);
    bus.a     = a;
    bus.b     = b;
    bus.ci    = ci;
`ifdef ADD8_SUB_MODE_EN
    bus.sub   = sub;
`else
    if (sub) $display("note: sub ignored in pure adder build");
`endif
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done, checking busy and held results on the way.
  task automatic wait_check(input string tag, input logic [W-1:0] exp_s, input logic exp_co,
                            input int exp_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat <= 4 * W) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_hold_s"}, 32'(bus.s), 32'(prev_s));
        chk({tag, "_hold_co"}, 32'(bus.co), 32'(prev_co));
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      chk({tag, "_s"}, 32'(bus.s), 32'(exp_s));
      chk({tag, "_co"}, 32'(bus.co), 32'(exp_co));
    end
    prev_s  = exp_s;
    prev_co = exp_co;
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    chk({tag, "_done_single"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rci, rsub;
    logic [W:0]   r;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.ci    = 1'b0;
`ifdef ADD8_SUB_MODE_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_s", 32'(bus.s), 32'd0);
    chk("rst_co", 32'(bus.co), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Carry through all bits.
    launch(8'hFF, 8'h7F, 1'b1, 1'b0);
    wait_check("carry", 8'h7F, 1'b1, W);
    after_done("carry");

    launch(8'h1F, 8'h0F, 1'b1, 1'b0);
    wait_check("nocarry", 8'h2F, 1'b0, W);
    after_done("nocarry");

    launch(8'h80, 8'h80, 1'b0, 1'b0);
    wait_check("msb_carry", 8'h00, 1'b1, W);
    after_done("msb_carry");

    // Busy lockout: a second start three cycles in is dropped.
    launch(8'h01, 8'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.a     = 8'h10;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_check("lockout", 8'h02, 1'b0, W - 3);

    // Back-to-back: start in the done cycle, old result held during RUN.
    launch(8'h00, 8'h01, 1'b0, 1'b0);
    wait_check("b2b", 8'h01, 1'b0, W);
    after_done("b2b");
    repeat (W) begin
      @(negedge clk);
      chk("no_extra_done", 32'(bus.done), 32'd0);
    end

    // Reset mid-operation.
    launch(8'hAA, 8'h55, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_s", 32'(bus.s), 32'd0);
    chk("abort_co", 32'(bus.co), 32'd0);
    prev_s  = '0;
    prev_co = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    launch(8'h3C, 8'h42, 1'b0, 1'b0);
    wait_check("post_abort", 8'h7E, 1'b0, W);
    after_done("post_abort");

    // Reset wins over start on the same edge.
    rst_n     = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    chk("rst_wins_busy", 32'(bus.busy), 32'd0);
    chk("rst_wins_s", 32'(bus.s), 32'd0);
    prev_s  = '0;
    prev_co = 1'b0;
    @(negedge clk);
    chk("rst_wins_still_idle", 32'(bus.busy), 32'd0);

`ifdef ADD8_SUB_MODE_EN
    launch(8'h00, 8'h01, 1'b1, 1'b1);
    wait_check("sub_neg", 8'hFF, 1'b0, W);
    after_done("sub_neg");
    launch(8'h10, 8'h01, 1'b1, 1'b1);
    wait_check("sub_pos", 8'h0F, 1'b1, W);
    after_done("sub_pos");
`endif

    // Randomized operands against the arithmetic model, alternating
    // back-to-back launches with idle gaps.
    for (int i = 0; i < 24; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rci = 1'($urandom);
`ifdef ADD8_SUB_MODE_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      r = ref_add(ra, rb, rci, rsub);
      launch(ra, rb, rci, rsub);
      wait_check("rand", r[W-1:0], r[W], W);
      if (i % 2 == 1) after_done("rand");
    end
    after_done("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
